ap_result_packer: RTL
=====================

Name: ap_result_packer

Overview:
Downstream stage of the matrix×vector dot-product feeder. It collects the scalar row results that the dot-product unit emits, one per finish pulse. It packs no_of_units consecutive results into one wide word and writes each word to the AP total memory with an auto-incrementing address. A final partial word is flushed zero-padded. Double-buffered so results arriving every cycle are never lost.

Parameters:
element_width, 32, bit width of one result element
no_of_units, 8, results packed per memory word (lanes)
addr_width, 10, AP memory address width

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse: begin a new collection run (IDLE or DONE only)
total  input  32  number of results expected in the run; latched on start
result  input  element_width  scalar dot-product result
result_valid  input  1  result is valid this cycle (driven by dot-product finish)
mem_wdata  output  element_width*no_of_units  packed word; lane k at bits [k*element_width +: element_width]
mem_addr  output  addr_width  AP memory word address
mem_we  output  1  one-cycle write strobe
count  output  32  results accepted in the current run
busy  output  1  high in COLLECT
done  output  1  run complete; held until start or reset
err  output  1  sticky: result_valid seen outside COLLECT

Behaviour:
- Reset is synchronous on clk and active-high, named reset; clock is clk. On reset: state=IDLE, mem_wdata=0, mem_addr=0, mem_we=0, count=0, busy=0, done=0, err=0, lane index=0, pack register=0. Reset mid-run aborts the run with no further writes.
- States: IDLE, COLLECT, DONE.
- IDLE/DONE + start: latch total, clear count, lane index, pack register, done and address. Next state is COLLECT. If total==0, go to DONE instead with no write; done rises the next cycle.
- COLLECT + result_valid: store result in lane[lane_index] of the pack register; lane_index++; count++.
- Word completion occurs when lane_index==no_of_units-1, or when count+1==latched total, in the accepting cycle N:
  - Cycle N+1: mem_wdata = packed word including the new result, with unfilled lanes 0; mem_we=1 for exactly one cycle; mem_addr = current word address.
  - Address increments after the write. It wraps modulo 2^addr_width.
  - The pack register and lane index clear in cycle N, so a result_valid at N+1 lands in lane 0 of the next word. Back-to-back results at 1 per cycle are fully supported.
- Last result accepted at cycle N: state moves to DONE at N+1, in the same cycle as the final mem_we. done=1 from N+1, held until the next start.
- Number of writes per run = ceil(total/no_of_units).
- mem_wdata holds its last written value between strobes. mem_we is 0 whenever it is not strobing.
- start during COLLECT is ignored.
- result_valid in IDLE or DONE is dropped and sets err; err clears only on reset.
- result_valid arriving in the same cycle as start in IDLE/DONE is dropped and sets err.
- busy = (state==COLLECT).

Decomposition:
- Shared package: default element_width, no_of_units and addr_width constants; state encoding (IDLE=0, COLLECT=1, DONE=2).
- Single module. An optional sub-module, lane_pack_reg (lane-indexed write register with clear), is natural but not required.

Test Plan:
1. no_of_units=8, total=16, results 1..16 on consecutive cycles -> two mem_we pulses at addr 0 and 1. Word 0 lanes = 1..8, word 1 lanes = 9..16. done high the same cycle as the 2nd strobe; count=16.
2. total=10, results 1..10 -> word 1 at addr 1 has lanes 0-1 = 9,10 and lanes 2-7 = 0; exactly 2 strobes.
3. total=0 start -> no mem_we; done=1 one cycle after start; count=0.
4. total=8, result_valid gapped (every 3rd cycle) -> single write, lanes 1..8 in order, mem_we exactly 1 cycle after the 8th valid.
5. Reset asserted after 5 of 16 results -> all outputs 0 the next cycle, no further writes. A new start with total=8 writes at addr 0.
6. result_valid in IDLE and after done -> err=1 and sticky; no write; count unchanged. start pulsed mid-COLLECT is ignored.

Source files
------------

// File: rtl/ap_result_packer_pkg.sv
// Shared defaults and state encoding for the AP result packer.
package ap_result_packer_pkg;

  localparam int unsigned DefElementWidth = 32;
  localparam int unsigned DefNoOfUnits    = 8;
  localparam int unsigned DefAddrWidth    = 10;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } state_e;

  // Lane index width; a single-lane packer still needs a 1-bit index.
  function automatic int unsigned lane_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ap_result_packer_lane_pack_reg.sv
// Lane-indexed pack register: merges one element into the held word, with clear.
module ap_result_packer_lane_pack_reg
  import ap_result_packer_pkg::*;
#(
  parameter int unsigned element_width = DefElementWidth,
  parameter int unsigned no_of_units   = DefNoOfUnits,
  parameter int unsigned LaneW         = lane_width(DefNoOfUnits)
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   clr_i,
  input  logic                                   wr_i,
  input  logic [LaneW-1:0]                       lane_i,
  input  logic [element_width-1:0]               data_i,
  output logic [element_width*no_of_units-1:0]   merged_o
);

  localparam int unsigned WordW = element_width * no_of_units;

  logic [WordW-1:0] pack_q, pack_d;

  // Held word with the incoming element already placed, so a completing word can be
  // written out in the same cycle the last element is accepted.
  always_comb begin
    merged_o = pack_q;
    for (int unsigned k = 0; k < no_of_units; k++) begin
      if (lane_i == LaneW'(k)) merged_o[k*element_width +: element_width] = data_i;
    end
  end

  always_comb begin
    pack_d = pack_q;
    if (clr_i) begin
      pack_d = '0;
    end else if (wr_i) begin
      pack_d = merged_o;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pack_q <= '0;
    end else begin
      pack_q <= pack_d;
    end
  end

endmodule

// File: rtl/ap_result_packer.sv
// Packs scalar dot-product results into wide words and writes them to AP total memory
// at auto-incrementing addresses; a trailing partial word is flushed zero-padded.
module ap_result_packer
  import ap_result_packer_pkg::*;
#(
  parameter int unsigned element_width = DefElementWidth,
  parameter int unsigned no_of_units   = DefNoOfUnits,
  parameter int unsigned addr_width    = DefAddrWidth
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [31:0]                          total,
  input  logic [element_width-1:0]             result,
  input  logic                                 result_valid,
  output logic [element_width*no_of_units-1:0] mem_wdata,
  output logic [addr_width-1:0]                mem_addr,
  output logic                                 mem_we,
  output logic [31:0]                          count,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 err
);

  localparam int unsigned LaneW = lane_width(no_of_units);
  localparam int unsigned WordW = element_width * no_of_units;

  state_e               state_q, state_d;
  logic [31:0]          total_q, total_d;
  logic [31:0]          count_q, count_d;
  logic [LaneW-1:0]     lane_q, lane_d;
  logic [addr_width-1:0] addr_q, addr_d;
  logic [WordW-1:0]     wdata_q, wdata_d;
  logic                 we_q, we_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;

  logic             pack_clr, pack_wr;
  logic [WordW-1:0] merged;
  logic             last_result, lane_full;

  ap_result_packer_lane_pack_reg #(
    .element_width(element_width),
    .no_of_units  (no_of_units),
    .LaneW        (LaneW)
  ) u_lane_pack_reg (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (pack_clr),
    .wr_i    (pack_wr),
    .lane_i  (lane_q),
    .data_i  (result),
    .merged_o(merged)
  );

  assign last_result = (count_q + 32'd1) == total_q;
  assign lane_full   = lane_q == LaneW'(no_of_units - 1);

  always_comb begin
    state_d  = state_q;
    total_d  = total_q;
    count_d  = count_q;
    lane_d   = lane_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
    done_d   = done_q;
    err_d    = err_q;
    pack_clr = 1'b0;
    pack_wr  = 1'b0;

    // Address advances the cycle after each strobe; a new start overrides below.
    if (we_q) addr_d = addr_q + 1'b1;

    unique case (state_q)
      StIdle, StDone: begin
        if (result_valid) err_d = 1'b1;
        if (start) begin
          total_d  = total;
          count_d  = '0;
          lane_d   = '0;
          addr_d   = '0;
          pack_clr = 1'b1;
          done_d   = (total == 32'd0);
          state_d  = (total == 32'd0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        if (result_valid) begin
          pack_wr = 1'b1;
          count_d = count_q + 32'd1;
          if (lane_full || last_result) begin
            wdata_d  = merged;
            we_d     = 1'b1;
            pack_clr = 1'b1;
            lane_d   = '0;
          end else begin
            lane_d = lane_q + 1'b1;
          end
          if (last_result) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      total_q <= '0;
      count_q <= '0;
      lane_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      count_q <= count_d;
      lane_q  <= lane_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign mem_wdata = wdata_q;
  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign count     = count_q;
  assign busy      = (state_q == StCollect);
  assign done      = done_q;
  assign err       = err_q;

endmodule
